// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int unsigned LSU_LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        MERGE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || (is_word(size) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational byte-lane logic: load extract/extend and store lane insert (little-endian).
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [1:0]             i_size,
    input  logic [1:0]             i_offset,
    input  logic                   i_signed,
    input  logic [LSU_LANES*8-1:0] i_word,
    input  logic [LSU_LANES*8-1:0] i_wdata,
    output logic [LSU_LANES*8-1:0] o_load,
    output logic [LSU_LANES*8-1:0] o_store
);

    localparam int unsigned W = LSU_LANES * 8;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_word[{i_offset, 3'b000} +: 8];
        w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];
        o_load  = i_word;
        o_store = i_wdata;
        // Halfword lane is chosen by offset[1] alone, so a stray offset[0] is ignored.
        if (i_size == SIZE_BYTE) begin
            o_load  = {{(W-8){i_signed & w_byte[7]}}, w_byte};
            o_store = i_word;
            o_store[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
        end else if (i_size == SIZE_HALF) begin
            o_load  = {{(W-16){i_signed & w_half[15]}}, w_half};
            o_store = i_word;
            o_store[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit in front of dataMemory; sub-word stores are read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN adds resp_err and traps misaligned requests.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              resp_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        r_state, w_state_nxt;
    logic              r_write, r_signed;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_merge, r_rdata;
    logic [DATA_W-1:0] w_merge_in, w_load, w_store;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_wr, w_trap;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_err;
    assign w_trap   = is_misaligned(req_size, req_addr[1:0]);
    assign resp_err = (r_state == RESP) && r_err;
`else
    assign w_trap = 1'b0;
`endif

    assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_merge_in  = (r_state == MERGE) ? r_merge : mem_rdata;
    assign resp_rdata  = r_rdata;

    lsu_lane_merge u_merge (
        .i_size   (r_size),
        .i_offset (r_addr[1:0]),
        .i_signed (r_signed),
        .i_word   (w_merge_in),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_store  (w_store)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_wr        = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = w_trap ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr    = w_word_addr;
                w_state_nxt = RESP;
                if (r_write) begin
                    if (is_word(r_size)) begin
                        w_wr      = 1'b1;
                        mem_wdata = r_wdata;
                    end else begin
                        w_state_nxt = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_addr    = w_word_addr;
                mem_wdata   = w_store;
                w_wr        = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gating with reset keeps a mid-operation reset from committing a level-sensitive write.
    assign mem_wr_en = w_wr && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_signed <= req_signed;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        if (w_trap) r_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        r_err    <= w_trap;
`endif
                    end
                end
                ACCESS: begin
                    if (r_write) begin
                        r_rdata <= '0;
                        r_merge <= mem_rdata;
                    end else begin
                        r_rdata <= w_load;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural dataMemory and response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr_en;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        resp_err;
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .resp_err   (resp_err),
`endif
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // dataMemory: combinational read, level-sensitive write sampled on the clock edge
    logic [31:0] mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_dat;
        if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_lat = 0;
    int resp_cnt = 0;
    int cur_acc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        int          wrlat;
        logic [31:0] memw;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor samples well after the falling edge so bench-driven reset changes have settled.
    always @(negedge clk) begin
        sb_t e;
        #2;
        if (mem_wr_en) begin
            wr_cnt++;
            wr_lat = cyc - cur_acc + 1;
            chk("wr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        end
        if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_resp actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_lat", cyc - e.acc + 1, e.lat);
`ifdef LSU_MISALIGN_TRAP_EN
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
`endif
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int  wr0;
        bit  done;
        sb_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        cur_acc   = cyc;
        wr0       = wr_cnt;
        e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.acc = cyc;
        sb.push_back(e);
        done = 1'b0;
        for (int t = 0; t < 20; t++) begin
            #3;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout actual=no_resp expected=resp", idx);
            sb.delete();
        end
        chk($sformatf("v%0d_wr_count", idx), wr_cnt - wr0, v.nwr);
        if (v.nwr != 0) chk($sformatf("v%0d_wr_lat", idx), wr_lat, v.wrlat);
        chk($sformatf("v%0d_mem", idx), mem[v.addr[7:2]], v.memw);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   wr0, rc0;
        sb_t  e;
        vec_t v;
        //                wr    size   sgn   addr       wdata         rdata         err   lat nwr wl  mem
        tbl[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 0, 32'h80FF7F01};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        32'h00000080, 1'b0, 2, 0, 0, 32'h80FF7F01};
        tbl[4]  = '{1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        32'h0000007F, 1'b0, 2, 0, 0, 32'h80FF7F01};
        tbl[5]  = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0, 0, 32'h80FF7F01};
        tbl[6]  = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        32'h00007F01, 1'b0, 2, 0, 0, 32'h80FF7F01};
        tbl[7]  = '{1'b1, 2'b00, 1'b0, 32'h31, 32'h123456AA, 32'h0,        1'b0, 3, 1, 2, 32'h1122AA44};
        tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h32, 32'h9999BEEF, 32'h0,        1'b0, 3, 1, 2, 32'hBEEFAA44};
        tbl[9]  = '{1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        32'hBEEFAA44, 1'b0, 2, 0, 0, 32'hBEEFAA44};
        tbl[10] = '{1'b0, 2'b00, 1'b0, 32'h30, 32'h0,        32'h00000044, 1'b0, 2, 0, 0, 32'hBEEFAA44};
        if (TRAP) begin
            tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h42, 32'h0,    32'h0,        1'b1, 1, 0, 0, 32'hCAFEF00D};
            tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h43, 32'h0,    32'h0,        1'b1, 1, 0, 0, 32'hCAFEF00D};
        end else begin
            tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h42, 32'h0,    32'hCAFEF00D, 1'b0, 2, 0, 0, 32'hCAFEF00D};
            tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h43, 32'h0,    32'hFFFFCAFE, 1'b0, 2, 0, 0, 32'hCAFEF00D};
        end
        tbl[13] = '{1'b0, 2'b11, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 0, 32'hCAFEF00D};
        tbl[14] = '{1'b1, 2'b00, 1'b0, 32'h40, 32'hFFFFFF55, 32'h0,        1'b0, 3, 1, 2, 32'hCAFEF055};
        if (TRAP) begin
            tbl[15] = '{1'b1, 2'b01, 1'b0, 32'h41, 32'h1234, 32'h0,        1'b1, 1, 0, 0, 32'hCAFEF055};
            tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,    32'hCAFEF055, 1'b0, 2, 0, 0, 32'hCAFEF055};
            tbl[17] = '{1'b0, 2'b00, 1'b0, 32'h42, 32'h0,    32'h000000FE, 1'b0, 2, 0, 0, 32'hCAFEF055};
        end else begin
            tbl[15] = '{1'b1, 2'b01, 1'b0, 32'h41, 32'h1234, 32'h0,        1'b0, 3, 1, 2, 32'hCAFE1234};
            tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,    32'hCAFE1234, 1'b0, 2, 0, 0, 32'hCAFE1234};
            tbl[17] = '{1'b0, 2'b00, 1'b0, 32'h42, 32'h0,    32'h000000FE, 1'b0, 2, 0, 0, 32'hCAFE1234};
        end

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        pl_we = 1'b0; pl_idx = '0; pl_dat = '0;

        // Preload memory while the unit is held in reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pl_we  = 1'b1;
            pl_idx = 6'(4 + 4 * i);
            case (i)
                0: pl_dat = 32'h00000000;
                1: pl_dat = 32'h80FF7F01;
                2: pl_dat = 32'h11223344;
                3: pl_dat = 32'hCAFEF00D;
                default: pl_dat = 32'h01020304;
            endcase
        end
        @(negedge clk);
        pl_we = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_mem_wr_en",  {31'd0, mem_wr_en},  32'd0);
        chk("rst_mem_addr",   mem_addr,            32'd0);
        chk("rst_mem_wdata",  mem_wdata,           32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(i, tbl[i]);

        // Back-to-back loads with req_valid held: accept every third cycle only
        rc0 = resp_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = '0;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("hs%0d_ready", k), {31'd0, req_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("hs%0d_resp", k), {31'd0, resp_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 1) begin
                e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.lat = 2; e.acc = cyc;
                sb.push_back(e);
                cur_acc = cyc;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        #1;
        chk("hs_ready_idle", {31'd0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        #3;
        chk("hs_resp_count", resp_cnt - rc0, 32'd3);
        chk("hs_sb_empty", sb.size(), 32'd0);
        chk("hs_rdata_hold", resp_rdata, 32'hDEADBEEF);
        sb.delete();

        // Reset asserted during the MERGE cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h000000FF;
        @(negedge clk);
        req_valid = 1'b0;
        cur_acc = cyc;
        wr0 = wr_cnt;
        rc0 = resp_cnt;
        @(negedge clk);
        chk("mg_wr_before_rst", {31'd0, mem_wr_en}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mg_wr_in_rst", {31'd0, mem_wr_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mg_ready_after", {31'd0, req_ready}, 32'd1);
        chk("mg_resp_after", {31'd0, resp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        #3;
        chk("mg_wr_count", wr_cnt - wr0, 32'd0);
        chk("mg_resp_count", resp_cnt - rc0, 32'd0);
        chk("mg_mem", mem[20], 32'h01020304);

        v = '{1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h01020304, 1'b0, 2, 0, 0, 32'h01020304};
        run_vec(18, v);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and dataMemory, directly upstream of the memory.
- Accepts byte, halfword and word loads/stores from the CPU and presents word-aligned byte addresses to dataMemory.
- Sign- or zero-extends load data.
- Performs sub-word stores as read-modify-write over two memory cycles, so dataMemory only ever writes whole words.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; fixed at 32, byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- mem_addr  out  32  word-aligned byte address to dataMemory, bits [1:0] = 0.
- mem_wr_en  out  1  dataMemory write enable.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  dataMemory combinational read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, mem_wr_en 0, mem_addr 0, mem_wdata 0.
- Byte lanes are little-endian: offset 0 = bits [7:0], halfword offset 2 = bits [31:16].
- Handshake: a request is accepted when req_valid && req_ready on a clk edge. All request fields are registered at acceptance.
- req_ready is 1 only in IDLE. No request is accepted in any other state, including RESP.
- IDLE -> ACCESS on acceptance.
- ACCESS: mem_addr = {addr[31:2],2'b00}.
  - Load: capture the extracted and extended lane from mem_rdata into resp_rdata -> RESP.
  - Word store: mem_wr_en=1, mem_wdata=wdata -> RESP.
  - Sub-word store: mem_wr_en=0, capture mem_rdata into merge register -> MERGE.
- MERGE: same mem_addr, mem_wr_en=1, mem_wdata = merge word with the target lane(s) replaced by wdata[7:0] or wdata[15:0] -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Latency from the acceptance edge (cycle 0): load and word store resp_valid in cycle 2; sub-word store resp_valid in cycle 3.
- mem_wr_en is asserted for exactly one cycle per store, since dataMemory writes level-sensitively. mem_addr and mem_wdata are stable throughout that cycle. mem_wr_en is 0 in every other state.
- mem_wr_en is gated with !reset, so no write occurs in a reset cycle even when reset is asserted mid-ACCESS or mid-MERGE.
- Reset mid-operation aborts the request: no resp_valid, return to IDLE.
- resp_rdata holds its value until the next load completes; stores set it to 0.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0), without the optional feature: the offending low bits are ignored. Half uses addr[1] only; word uses lane 0.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output resp_err (1 bit, reset 0).
  - A misaligned request is accepted, performs no memory access (mem_wr_en stays 0), and goes IDLE -> RESP directly.
  - RESP signals resp_valid=1, resp_err=1, resp_rdata=0.
  - Aligned requests drive resp_err=0.
- Undefined: port absent; low bits ignored as stated in Behaviour.

Decomposition:
- Package lsu_pkg holds:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - State encoding IDLE/ACCESS/MERGE/RESP (2-bit).
  - Lane-count constant 4.
- Sub-module lsu_lane_merge: purely combinational.
  - Extract + sign/zero-extend for loads.
  - Lane insert for stores, from (size, offset, signed, word_in, wdata).
  - Shared by ACCESS and MERGE logic.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF -> mem_wr_en pulse in cycle 1, resp_valid cycle 2. Load word 0x10 -> resp_rdata 0xDEADBEEF at cycle 2.
- Signed/unsigned byte load: mem word at 0x20 = 0x80FF7F01. lb 0x23 signed -> 0xFFFFFF80. lbu 0x23 -> 0x00000080. lb 0x21 signed -> 0x0000007F.
- Sub-word store RMW: mem 0x30 = 0x11223344. sb 0x31 data 0xAA -> single write cycle 2 of 0x1122AA44, resp_valid cycle 3. sh 0x32 data 0xBEEF -> 0xBEEFAA44.
- Handshake: hold req_valid high across back-to-back requests -> req_ready low in ACCESS/MERGE/RESP, no second acceptance before return to IDLE, exactly one resp_valid per request.
- Reset mid-MERGE: assert reset during an sb's MERGE cycle -> mem_wr_en 0 that cycle, memory unchanged, no resp_valid, req_ready 1 next cycle.
- Misaligned word load 0x42: without the macro -> reads word 0x40. With LSU_MISALIGN_TRAP_EN -> resp_err=1, resp_rdata 0, resp_valid in cycle 1, no memory write.
